// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sweep controller.
// COUNTER_SWEEP_WDOG_EN adds the stall-watchdog error state.
package counter_ctrl_pkg;

   localparam int SWEEP_CNT_W     = 8;
   localparam int WDOG_CYCLES_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DOWN,
      ST_UP,
      ST_DONE
`ifdef COUNTER_SWEEP_WDOG_EN
      , ST_ERR
`endif
   } sweep_state_t;

   function automatic logic [SWEEP_CNT_W-1:0] sat_inc(input logic [SWEEP_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/counter_sweep_ctrl_watchdog.sv
// Stall detector: flags when counter_value has not moved for WDOG_CYCLES
// consecutive active cycles. Only instantiated with COUNTER_SWEEP_WDOG_EN.
module sweep_watchdog #(
   parameter int N           = 32,
   parameter int WDOG_CYCLES = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         active,
   input  logic [N-1:0] counter_value,
   output logic         trip
);

   localparam int CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
   localparam logic [CW-1:0] LEFT_INIT = CW'(WDOG_CYCLES - 1);

   logic [N-1:0]  prev_q;
   logic [CW-1:0] left_q;
   logic          stalled;

   assign stalled = active && (counter_value == prev_q);
   assign trip    = stalled && (left_q == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prev_q <= '0;
         left_q <= LEFT_INIT;
      end else begin
         prev_q <= counter_value;
         if (!stalled)
            left_q <= LEFT_INIT;
         else if (left_q != '0)
            left_q <= left_q - 1'b1;
      end
   end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Drives load/dec/enable of an N-bit up/down counter through repeated
// ref -> 0 -> ref sweeps. Optional watchdog: COUNTER_SWEEP_WDOG_EN.
//
// state | meaning
// IDLE  | waiting for start, counter untouched
// LOAD  | one-cycle load of captured reference
// DOWN  | counting down towards zero
// UP    | counting up back to reference
// DONE  | one-cycle completion pulse
// ERR   | counter stalled (watchdog build only), held until stop
module counter_sweep_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int N           = 32,
   parameter int SWEEPS      = 4,
   parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   pause,
   input  logic [N-1:0]           ref_value,
   input  logic [N-1:0]           counterN,
   output logic                   load,
   output logic                   dec,
   output logic                   enable,
   output logic [N-1:0]           Load_Ref_value,
   output logic                   busy,
   output logic                   done,
   output logic [SWEEP_CNT_W-1:0] sweep_cnt,
   output logic                   err
);

   if (WDOG_CYCLES < 1 || N < 1) begin : g_bad_cfg
      $error("counter_sweep_ctrl: WDOG_CYCLES and N must be at least 1");
   end

   sweep_state_t           state_q, state_nxt;
   logic [N-1:0]           ref_q;
   logic [SWEEP_CNT_W-1:0] sweep_cnt_q, cnt_inc;
   logic                   start_acc, sweep_done;
   logic                   at_bottom, at_top;

   assign cnt_inc   = sat_inc(sweep_cnt_q);
   // Exit one count early: the counter takes its final step on the same edge.
   assign at_bottom = (counterN == N'(1));
   assign at_top    = (counterN == ref_q - N'(1));

`ifdef COUNTER_SWEEP_WDOG_EN
   logic wdog_trip;
   logic err_q;

   sweep_watchdog #(
      .N           (N),
      .WDOG_CYCLES (WDOG_CYCLES)
   ) u_watchdog (
      .clock         (clock),
      .reset         (reset),
      .active        (enable && (state_q == ST_DOWN || state_q == ST_UP)),
      .counter_value (counterN),
      .trip          (wdog_trip)
   );
`endif

   always_comb begin
      state_nxt  = state_q;
      start_acc  = 1'b0;
      sweep_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_LOAD;
               start_acc = 1'b1;
            end
         end
         ST_LOAD: state_nxt = (ref_q == '0) ? ST_DONE : ST_DOWN;
         ST_DOWN: begin
            if (!pause) begin
`ifdef COUNTER_SWEEP_WDOG_EN
               if (wdog_trip)
                  state_nxt = ST_ERR;
               else
`endif
               if (at_bottom)
                  state_nxt = ST_UP;
            end
         end
         ST_UP: begin
            if (!pause) begin
`ifdef COUNTER_SWEEP_WDOG_EN
               if (wdog_trip)
                  state_nxt = ST_ERR;
               else
`endif
               if (at_top) begin
                  sweep_done = 1'b1;
                  if (SWEEPS != 0 && 32'(cnt_inc) == 32'(SWEEPS))
                     state_nxt = ST_DONE;
                  else
                     state_nxt = ST_DOWN;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = state_q;
      endcase
      if (stop) begin
         state_nxt  = ST_IDLE;
         start_acc  = 1'b0;
         sweep_done = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         ref_q       <= '0;
         sweep_cnt_q <= '0;
      end else begin
         state_q <= state_nxt;
         if (start_acc) begin
            ref_q       <= ref_value;
            sweep_cnt_q <= '0;
         end else if (sweep_done) begin
            sweep_cnt_q <= cnt_inc;
         end
      end
   end

`ifdef COUNTER_SWEEP_WDOG_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         err_q <= 1'b0;
      else if (start_acc)
         err_q <= 1'b0;
      else if (state_nxt == ST_ERR)
         err_q <= 1'b1;
   end
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Stop gates enable at once so the counter does not take one more step.
   assign load           = (state_q == ST_LOAD);
   assign dec            = (state_q == ST_DOWN);
   assign enable         = !stop && ((state_q == ST_LOAD) ||
                           (((state_q == ST_DOWN) || (state_q == ST_UP)) && !pause));
   assign busy           = (state_q != ST_IDLE);
   assign done           = (state_q == ST_DONE);
   assign Load_Ref_value = ref_q;
   assign sweep_cnt      = sweep_cnt_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: behavioural counter plus a progress-based
// reference model checked every cycle, and directed literal expectations.
module tb_counter_sweep_ctrl;

   localparam int N      = 32;
   localparam int SWEEPS = 2;
   localparam int WDOG   = 16;

   logic         clock = 1'b0;
   logic         reset;
   logic         start, stop, pause;
   logic [N-1:0] ref_value;
   logic [N-1:0] counterN;
   logic         load, dec, enable, busy, done, err;
   logic [N-1:0] Load_Ref_value;
   logic [7:0]   sweep_cnt;

   logic [N-1:0] cnt_q;
   logic         stuck;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   counter_sweep_ctrl #(.N(N), .SWEEPS(SWEEPS), .WDOG_CYCLES(WDOG)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .stop           (stop),
      .pause          (pause),
      .ref_value      (ref_value),
      .counterN       (counterN),
      .load           (load),
      .dec            (dec),
      .enable         (enable),
      .Load_Ref_value (Load_Ref_value),
      .busy           (busy),
      .done           (done),
      .sweep_cnt      (sweep_cnt),
      .err            (err)
   );

   // Behavioural counter; a stuck counter reads a constant 7.
   always @(posedge clock or negedge reset) begin
      if (!reset)      cnt_q <= '0;
      else if (load)   cnt_q <= Load_Ref_value;
      else if (enable) cnt_q <= dec ? cnt_q - 1 : cnt_q + 1;
   end
   assign counterN = stuck ? 32'd7 : cnt_q;

   // Model: phase 0 idle, 1 load, 2 sweeping, 3 done, 4 error.
   // m_p counts completed counting cycles of the sweep phase.
   int              m_phase;
   longint unsigned m_p, m_ref;
   int              m_sc, m_stall;
   logic            m_err;
   logic [N-1:0]    m_prev;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_phase = 0; m_p = 0; m_ref = 0; m_sc = 0; m_err = 0; m_stall = 0; m_prev = '0;
      end else begin
         if (!(m_phase == 2 && !pause && !stop)) m_stall = 0;
         if (stop) m_phase = 0;
         else case (m_phase)
            0: if (start) begin
                  m_phase = 1; m_ref = longint'(ref_value); m_sc = 0; m_err = 0; m_p = 0;
               end
            1: m_phase = (m_ref == 0) ? 3 : 2;
            2: if (!pause) begin
`ifdef COUNTER_SWEEP_WDOG_EN
                  if (counterN == m_prev) m_stall++; else m_stall = 0;
                  if (m_stall == WDOG) begin m_phase = 4; m_err = 1; end
`endif
                  if (m_phase == 2) begin
                     m_p++;
                     if (m_p % (2 * m_ref) == 0) m_sc = (m_sc == 255) ? 255 : m_sc + 1;
                     if (SWEEPS != 0 && m_p == longint'(SWEEPS) * 2 * m_ref) m_phase = 3;
                  end
               end
            3: m_phase = 0;
            default: ;
         endcase
         m_prev = counterN;
      end
   end

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      longint unsigned q;
      logic e_en, e_dec;
      q     = (m_phase == 2) ? m_p % (2 * m_ref) : 0;
      e_dec = (m_phase == 2) && (q < m_ref);
      e_en  = !stop && ((m_phase == 1) || (m_phase == 2 && !pause));
      chk("m_load",   load,   m_phase == 1);
      chk("m_dec",    dec,    e_dec);
      chk("m_enable", enable, e_en);
      chk("m_busy",   busy,   m_phase != 0);
      chk("m_done",   done,   m_phase == 3);
      chk("m_sweep_cnt", sweep_cnt, m_sc);
      chk("m_ref",    Load_Ref_value, m_ref);
      chk("m_err",    err,    m_err);
      if (m_phase == 2 && !stuck)
         chk("m_counterN", counterN, (q < m_ref) ? m_ref - q : q - m_ref);
   endtask

   logic         s_done, s_en, s_busy, s_load, s_err;
   logic [N-1:0] s_cn;

   task automatic cyc();
      @(negedge clock);
      model_check();
      s_done = done; s_en = enable; s_busy = busy; s_load = load; s_err = err; s_cn = counterN;
      @(posedge clock);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int at, load_at, done_cnt;
      logic [N-1:0] seq [8];
      int exp_seq [8] = '{4, 3, 2, 1, 0, 1, 2, 3};
      logic [N-1:0] cn8;
      logic en8;

      reset = 1'b0; start = 0; stop = 0; pause = 0; ref_value = '0; stuck = 0;
      repeat (3) cyc();
      chk("rst_busy", busy, 0); chk("rst_enable", enable, 0); chk("rst_ref", Load_Ref_value, 0);
      reset = 1'b1;
      cyc();

      // ref=4, two sweeps
      ref_value = 4; start = 1; cyc(); start = 0;
      at = 0;
      for (int i = 1; i <= 30; i++) begin
         cyc();
         if (i >= 2 && i <= 9) seq[i-2] = s_cn;
         if (i == 1) chk("a_load_cycle1", s_load, 1);
         if (s_done && at == 0) at = i;
      end
      chk("a_done_at", at, 18);
      for (int k = 0; k < 8; k++) chk("a_counter_seq", seq[k], exp_seq[k]);
      chk("a_sweep_cnt", sweep_cnt, 2);

      // ref=0
      ref_value = 0; start = 1; cyc(); start = 0;
      at = 0;
      for (int i = 1; i <= 6; i++) begin
         cyc();
         if (s_done && at == 0) at = i;
      end
      chk("b_done_at", at, 2);
      chk("b_sweep_cnt", sweep_cnt, 0);
      chk("b_counter", counterN, 0);

      // pause 5 cycles in DOWN at counterN=2
      ref_value = 4; start = 1; cyc(); start = 0;
      at = 0; cn8 = '0; en8 = 1;
      for (int i = 1; i <= 30; i++) begin
         cyc();
         if (i == 8) begin cn8 = s_cn; en8 = s_en; end
         if (s_done && at == 0) at = i;
         pause = (i >= 3 && i < 8);
      end
      chk("c_paused_cn", cn8, 2);
      chk("c_paused_en", en8, 0);
      chk("c_done_at", at, 23);

      // stop in UP of second sweep at counterN=3
      ref_value = 4; start = 1; cyc(); start = 0;
      done_cnt = 0;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         if (s_done) done_cnt++;
         stop = (i == 16);
      end
      cyc();
      chk("d_stop_cn", s_cn, 3);
      chk("d_stop_en", s_en, 0);
      stop = 0;
      cyc();
      chk("d_busy", s_busy, 0);
      chk("d_en", s_en, 0);
      repeat (4) begin cyc(); if (s_done) done_cnt++; end
      chk("d_no_done", done_cnt, 0);
      chk("d_sweep_cnt", sweep_cnt, 1);

      // asynchronous reset between edges
      ref_value = 4; start = 1; cyc(); start = 0;
      repeat (5) cyc();
      #1 reset = 1'b0;
      #1;
      chk("e_load", load, 0); chk("e_dec", dec, 0); chk("e_enable", enable, 0);
      chk("e_ref", Load_Ref_value, 0); chk("e_busy", busy, 0); chk("e_done", done, 0);
      chk("e_sweep_cnt", sweep_cnt, 0); chk("e_err", err, 0);
      @(posedge clock); #2;
      reset = 1'b1;
      cyc();
      ref_value = 3; start = 1; cyc(); start = 0;
      at = 0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (s_done && at == 0) at = i;
      end
      chk("e_done_at", at, 14);
      chk("e_sweep_cnt_after", sweep_cnt, 2);

      // start held high re-arms after one IDLE cycle
      ref_value = 1; start = 1; cyc();
      at = 0; load_at = 0;
      for (int i = 1; i <= 10; i++) begin
         cyc();
         if (s_done && at == 0) at = i;
         if (at != 0 && s_load && load_at == 0) load_at = i;
      end
      chk("f_done_at", at, 6);
      chk("f_reload_at", load_at, 8);
      start = 0;
      repeat (12) cyc();

`ifdef COUNTER_SWEEP_WDOG_EN
      // stalled counter trips the watchdog
      stuck = 1; ref_value = 4; start = 1; cyc(); start = 0;
      for (int i = 1; i <= 18; i++) cyc();
      chk("g_err", s_err, 1); chk("g_en", s_en, 0); chk("g_busy", s_busy, 1);
      stop = 1; cyc(); stop = 0; cyc();
      chk("g_idle_busy", s_busy, 0); chk("g_err_sticky", s_err, 1);
      stuck = 0; ref_value = 1; start = 1; cyc(); start = 0; cyc();
      chk("g_err_cleared", s_err, 0);
      repeat (8) cyc();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Command-side driver for the team's N-bit loadable up/down counter (load/dec/enable/Load_Ref_value in, counterN out). On a start request it loads a reference value into the counter, then sweeps it down to zero and back up to the reference a programmable number of times, with pause and abort. It sits between the board control inputs and the counter instance, replacing hand-driven load/dec/enable.

## Interface
- N, 32, counter width; must match the driven counter.
- SWEEPS, 4, full down-up sweeps per start; 0 = run until stop.
- WDOG_CYCLES, 16, stall limit for the watchdog (only used with the watchdog macro).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; one clock domain.
- start  in  1  level; sampled in IDLE only.
- stop  in  1  synchronous abort; wins over every other input.
- pause  in  1  freeze sweep while high; state and counter held.
- ref_value  in  N  reference; captured on accepted start.
- counterN  in  N  current count read back from the counter.
- load  out  1  to counter load.
- dec  out  1  to counter dec (1 = count down).
- enable  out  1  to counter enable.
- Load_Ref_value  out  N  to counter Load_Ref_value; captured reference register.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on completion.
- sweep_cnt  out  8  completed sweeps since last start, saturates at 255.
- err  out  1  watchdog flag; sticky until next start or reset.

## Operation
- States: IDLE, LOAD, DOWN, UP, DONE (ERR with watchdog).
- Outputs are Moore, combinational from state, so counter and controller update on the same edge.
- IDLE: load=0, enable=0, dec=0. start=1 -> capture ref_value into Load_Ref_value, clear sweep_cnt and err, go LOAD.
- LOAD: load=1, enable=1 for exactly one cycle. Captured ref=0 -> DONE; else -> DOWN.
- DOWN: enable=1, dec=1. Leave when counterN==1 and pause=0 (counter reaches 0 on that edge) -> UP.
- UP: enable=1, dec=0. Leave when counterN==ref-1 and pause=0 -> one sweep complete, sweep_cnt+1; if SWEEPS!=0 and count reaches SWEEPS -> DONE, else -> DOWN.
- DONE: done=1 one cycle, enable=0 -> IDLE.
- pause=1 in DOWN/UP: enable=0, dec held, no transitions; pause ignored in IDLE/LOAD/DONE.
- stop=1 in any state: next state IDLE, enable=0, no done pulse; sweep_cnt retained.
- ref=1: DOWN exits on first cycle, UP exits on first cycle (counterN==0); each sweep is 2 cycles.
- ref=2^N-1 is legal; comparisons are N-bit unsigned, no wrap.

## Timing
- Reset values: load=0, dec=0, enable=0, Load_Ref_value=0, busy=0, done=0, sweep_cnt=0, err=0, state IDLE.
- start to load high: 1 cycle. Each sweep without pause: 2*ref cycles.
- Total start to done pulse: 1 (LOAD) + SWEEPS*2*ref + 1 cycles.
- start held high through DONE re-arms after returning to IDLE (one idle cycle minimum).
- Reset asserted mid-sweep: outputs drop to reset values immediately (asynchronous).

## Configuration
- COUNTER_SWEEP_WDOG_EN defined: in DOWN/UP with enable=1, counterN unchanged for WDOG_CYCLES consecutive cycles -> ERR state (enable=0, busy=1, err=1); leaves only on stop (-> IDLE) or reset.
- Not defined: no watchdog logic, ERR state absent, err tied 0.

## Structure
- Package counter_ctrl_pkg: state enum type, sweep counter width constant (8), default WDOG_CYCLES.
- One sub-module: sweep_watchdog (stall counter, compare of counterN with its previous value), instantiated only under the macro.

## Test plan
- Bench uses a behavioural counter model (load -> Load_Ref_value, enable/dec up/down).
- N=32, SWEEPS=2, ref=4, start pulse -> load 1 cycle, counterN 4,3,2,1,0,1,2,3,4,3,..,4; done pulse 18 cycles after start; sweep_cnt=2.
- ref=0, start -> LOAD then done next cycle, sweep_cnt=0, counter never enabled.
- ref=4, pause high 5 cycles in DOWN at counterN=2 -> enable low, counterN holds 2, resumes, done delayed exactly 5 cycles.
- stop asserted in UP at counterN=3 -> next cycle IDLE, enable=0, busy=0, no done pulse.
- Reset driven low mid-sweep between edges -> all outputs at reset values immediately; start after release runs normally.
- Macro defined, model counter ignores enable -> err=1 and enable=0 after 16 stalled cycles; stop returns to IDLE, err stays 1 until next start.
